// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INS_BYTES = 4;
    localparam logic [31:0] NOP_INS   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/fetch_target_gen.sv
// Redirect target generator: absolute (bit 0 cleared) or base-relative target,
// word-aligned when the alignment check is off, plus a misalignment flag when it is on.
module fetch_target_gen
    import fetch_pkg::*;
#(
    parameter int unsigned dataW       = 32,
    parameter bit          ALIGN_CHECK = 1'b0
) (
    input  logic             abs_i,
    input  logic [dataW-1:0] base_i,
    input  logic [dataW-1:0] offset_i,
    output logic [dataW-1:0] target_c,
    output logic             misalign_c
);

    logic [dataW-1:0] raw_target;

    // Sum wraps modulo 2^dataW by construction.
    always_comb begin
        raw_target = abs_i ? {offset_i[dataW-1:1], 1'b0} : (base_i + offset_i);
        target_c   = ALIGN_CHECK ? raw_target : {raw_target[dataW-1:2], 2'b00};
        misalign_c = ALIGN_CHECK & is_misaligned(raw_target[1:0]);
    end

endmodule

// File: rtl/fetch_unit_r32i.sv
// RV32I fetch stage: owns the PC, fetches one word per req/ack, hands it to the decoder.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirects raise a sticky FetchFault.
module fetch_unit_r32i
    import fetch_pkg::*;
#(
    parameter int unsigned      dataW        = 32,
    parameter logic [dataW-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             BranchTaken,
    input  logic             AbsoluteBranch,
    input  logic [dataW-1:0] BranchAddr,
    output logic             IMemReq,
    output logic [dataW-1:0] IMemAddr,
    input  logic             IMemAck,
    input  logic [dataW-1:0] IMemData,
    output logic [dataW-1:0] rawIns,
    output logic [dataW-1:0] ProgAddr,
    output logic             InsValid,
    input  logic             InsReady,
    output logic             FetchFault
);

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    fetch_state_t     state_q, state_d;
    logic [dataW-1:0] pc_q, pc_d;
    logic [dataW-1:0] issued_pc_q, issued_pc_d;
    logic [dataW-1:0] ins_q, ins_d;
    logic [dataW-1:0] prog_addr_q, prog_addr_d;
    logic [dataW-1:0] req_addr_q, req_addr_d;
    logic             req_q, req_d;
    logic             valid_q, valid_d;
    logic             discard_q, discard_d;
    logic             fault_q, fault_d;

    logic [dataW-1:0] target_c;
    logic             misalign_c;

    fetch_target_gen #(
        .dataW       (dataW),
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_target_gen (
        .abs_i      (AbsoluteBranch),
        .base_i     (issued_pc_q),
        .offset_i   (BranchAddr),
        .target_c   (target_c),
        .misalign_c (misalign_c)
    );

    // Next-state logic; a redirect outranks any ack or accept in the same cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        ins_d       = ins_q;
        prog_addr_d = prog_addr_q;
        req_addr_d  = req_addr_q;
        discard_d   = discard_q;
        fault_d     = fault_q;

        case (state_q)
            IDLE: begin
                state_d    = REQ;
                req_addr_d = pc_q;
            end

            REQ: begin
                if (BranchTaken) begin
                    if (misalign_c) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d = target_c;
                        if (IMemAck) begin
                            discard_d  = 1'b0;
                            req_addr_d = target_c;
                        end else begin
                            // The outstanding reply belongs to the old path; keep the
                            // address stable until it lands, then fetch the target.
                            discard_d = 1'b1;
                        end
                    end
                end else if (IMemAck) begin
                    if (discard_q) begin
                        discard_d  = 1'b0;
                        req_addr_d = pc_q;
                    end else begin
                        ins_d       = IMemData;
                        prog_addr_d = req_addr_q;
                        pc_d        = pc_q + dataW'(INS_BYTES);
                        state_d     = VALID;
                    end
                end
            end

            VALID: begin
                if (BranchTaken) begin
                    if (misalign_c) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d       = target_c;
                        req_addr_d = target_c;
                        state_d    = REQ;
                    end
                end else if (InsReady) begin
                    issued_pc_d = prog_addr_q;
                    req_addr_d  = pc_q;
                    state_d     = REQ;
                end
            end

            FAULT: begin
                state_d = FAULT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        req_d   = (state_d == REQ);
        valid_d = (state_d == VALID);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_VECTOR;
            issued_pc_q <= RESET_VECTOR;
            ins_q       <= dataW'(NOP_INS);
            prog_addr_q <= RESET_VECTOR;
            req_addr_q  <= RESET_VECTOR;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            discard_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            ins_q       <= ins_d;
            prog_addr_q <= prog_addr_d;
            req_addr_q  <= req_addr_d;
            req_q       <= req_d;
            valid_q     <= valid_d;
            discard_q   <= discard_d;
            fault_q     <= fault_d;
        end
    end

    assign IMemReq    = req_q;
    assign IMemAddr   = req_addr_q;
    assign rawIns     = ins_q;
    assign ProgAddr   = prog_addr_q;
    assign InsValid   = valid_q;
    assign FetchFault = fault_q;

endmodule

// File: tb/tb_fetch_unit_r32i.sv
// Directed bench for fetch_unit_r32i with an instruction-memory model and scoreboards
// for expected fetch addresses and expected delivered instructions.
module tb_fetch_unit_r32i;

    logic        clk;
    logic        nReset;
    logic        BranchTaken;
    logic        AbsoluteBranch;
    logic [31:0] BranchAddr;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] rawIns;
    logic [31:0] ProgAddr;
    logic        InsValid;
    logic        InsReady;
    logic        FetchFault;

    // Second instance with a wrapping reset vector.
    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] data2;
    logic [31:0] raw2;
    logic [31:0] prog2;
    logic        valid2;
    logic        fault2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_req[$];
    logic [31:0] exp_ins[$];

    int          ack_delay = 0;
    int          cnt       = 0;
    int          cyc       = 0;
    int          acc_cnt   = 0;
    int          last_acc  = -1;
    bit          period_chk = 1'b0;
    logic        req_prev  = 1'b0;
    logic [31:0] addr_prev = '0;
    logic [31:0] cap2[2];
    int          n2 = 0;

    fetch_unit_r32i #(.dataW(32), .RESET_VECTOR(32'h0000_0000)) u_dut (
        .clk            (clk),
        .nReset         (nReset),
        .BranchTaken    (BranchTaken),
        .AbsoluteBranch (AbsoluteBranch),
        .BranchAddr     (BranchAddr),
        .IMemReq        (IMemReq),
        .IMemAddr       (IMemAddr),
        .IMemAck        (IMemAck),
        .IMemData       (IMemData),
        .rawIns         (rawIns),
        .ProgAddr       (ProgAddr),
        .InsValid       (InsValid),
        .InsReady       (InsReady),
        .FetchFault     (FetchFault)
    );

    fetch_unit_r32i #(.dataW(32), .RESET_VECTOR(32'hFFFF_FFFC)) u_dut_wrap (
        .clk            (clk),
        .nReset         (nReset),
        .BranchTaken    (1'b0),
        .AbsoluteBranch (1'b0),
        .BranchAddr     (32'h0),
        .IMemReq        (req2),
        .IMemAddr       (addr2),
        .IMemAck        (ack2),
        .IMemData       (data2),
        .rawIns         (raw2),
        .ProgAddr       (prog2),
        .InsValid       (valid2),
        .InsReady       (1'b1),
        .FetchFault     (fault2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    assign ack2  = req2;
    assign data2 = mem_word(addr2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (InsValid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(InsValid), 32'd1);
    endtask

    // Memory model, address-stability monitor and delivery scoreboard.
    always @(negedge clk) begin
        logic [31:0] e;
        cyc++;
        if (!nReset) begin
            IMemAck  = 1'b0;
            IMemData = '0;
            cnt      = 0;
            req_prev = 1'b0;
        end else begin
            if (req_prev && !IMemAck && IMemReq)
                chk("addr_stable", IMemAddr, addr_prev);
            req_prev  = IMemReq;
            addr_prev = IMemAddr;

            if (IMemAck) begin
                IMemAck = 1'b0;
                cnt     = 0;
            end else if (IMemReq) begin
                if (cnt >= ack_delay) begin
                    IMemAck  = 1'b1;
                    IMemData = mem_word(IMemAddr);
                    if (exp_req.size() == 0) begin
                        chk("req_unexpected", 32'(exp_req.size()), 32'd1);
                    end else begin
                        e = exp_req.pop_front();
                        chk("req_addr", IMemAddr, e);
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end

            if (InsValid && InsReady && !BranchTaken) begin
                if (exp_ins.size() == 0) begin
                    chk("ins_unexpected", 32'(exp_ins.size()), 32'd1);
                end else begin
                    e = exp_ins.pop_front();
                    chk("prog_addr", ProgAddr, e);
                    chk("raw_ins", rawIns, mem_word(e));
                end
                if (period_chk && last_acc >= 0)
                    chk("ins_period", 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
                acc_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (nReset && req2 && n2 < 2) begin
            cap2[n2] = addr2;
            n2++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nReset         = 1'b0;
        BranchTaken    = 1'b0;
        AbsoluteBranch = 1'b0;
        BranchAddr     = '0;
        InsReady       = 1'b0;
        ack_delay      = 0;

        // Reset state
        repeat (3) step();
        chk("rst_req",    32'(IMemReq),    32'd0);
        chk("rst_valid",  32'(InsValid),   32'd0);
        chk("rst_raw",    rawIns,          32'h0000_0013);
        chk("rst_prog",   ProgAddr,        32'h0);
        chk("rst_fault",  32'(FetchFault), 32'd0);
        chk("rst_addr",   IMemAddr,        32'h0);
        chk("rst_addr2",  addr2,           32'hFFFF_FFFC);

        // Sequential fetch at full rate
        for (int i = 0; i <= 8; i++) exp_req.push_back(32'(i * 4));
        for (int i = 0; i < 8; i++)  exp_ins.push_back(32'(i * 4));
        period_chk = 1'b1;
        last_acc   = -1;
        InsReady   = 1'b1;
        nReset     = 1'b1;
        n = 0;
        while (acc_cnt < 8 && n < 200) begin
            step();
            n++;
        end
        InsReady   = 1'b0;
        period_chk = 1'b0;
        chk("seq_count", 32'(acc_cnt), 32'd8);

        // Decoder stall: instruction held, no new fetch
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall_prog", ProgAddr, 32'h20);
            chk("stall_raw",  rawIns,   mem_word(32'h20));
            chk("stall_req",  32'(IMemReq), 32'd0);
            chk("stall_addr", IMemAddr, 32'h20);
            step();
        end
        exp_ins.push_back(32'h20);
        exp_req.push_back(32'h24);
        InsReady = 1'b1;
        step();
        InsReady = 1'b0;

        // Absolute redirect in VALID kills the held instruction
        wait_valid("abs");
        chk("abs_held", ProgAddr, 32'h24);
        exp_req.push_back(32'h100);
        BranchTaken    = 1'b1;
        AbsoluteBranch = 1'b1;
        BranchAddr     = 32'h100;
        InsReady       = 1'b1;
        step();
        BranchTaken = 1'b0;
        InsReady    = 1'b0;
        chk("abs_kill",  32'(InsValid), 32'd0);
        chk("abs_req",   32'(IMemReq),  32'd1);
        chk("abs_addr",  IMemAddr,      32'h100);
        wait_valid("abs_tgt");
        chk("abs_prog",  ProgAddr,      32'h100);

        // Move to 0x20 and accept it so the relative base is 0x20
        exp_req.push_back(32'h20);
        BranchTaken = 1'b1;
        BranchAddr  = 32'h20;
        step();
        BranchTaken = 1'b0;
        wait_valid("base");
        chk("base_prog", ProgAddr, 32'h20);
        ack_delay = 3;
        exp_ins.push_back(32'h20);
        InsReady = 1'b1;
        step();
        InsReady = 1'b0;

        // Relative redirect while a fetch is in flight
        chk("rel_req", 32'(IMemReq), 32'd1);
        exp_req.push_back(32'h24);
        exp_req.push_back(32'h10);
        BranchTaken    = 1'b1;
        AbsoluteBranch = 1'b0;
        BranchAddr     = 32'hFFFF_FFF0;
        step();
        BranchTaken = 1'b0;
        n = 0;
        while (IMemAddr !== 32'h10 && n < 20) begin
            chk("rel_novalid", 32'(InsValid), 32'd0);
            step();
            n++;
        end
        chk("rel_addr", IMemAddr, 32'h10);
        wait_valid("rel");
        chk("rel_prog", ProgAddr, 32'h10);
        chk("rel_raw",  rawIns,   mem_word(32'h10));

        // Reset pulse with a request outstanding
        ack_delay = 5;
        exp_ins.push_back(32'h10);
        InsReady = 1'b1;
        step();
        InsReady = 1'b0;
        chk("mid_req", 32'(IMemReq), 32'd1);
        nReset = 1'b0;
        #1;
        chk("mid_rst_req",   32'(IMemReq),    32'd0);
        chk("mid_rst_valid", 32'(InsValid),   32'd0);
        chk("mid_rst_raw",   rawIns,          32'h0000_0013);
        chk("mid_rst_prog",  ProgAddr,        32'h0);
        chk("mid_rst_fault", 32'(FetchFault), 32'd0);
        chk("mid_rst_addr",  IMemAddr,        32'h0);
        repeat (2) step();
        exp_req.push_back(32'h0);
        ack_delay = 0;
        nReset    = 1'b1;
        n = 0;
        while (IMemReq !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("post_rst_addr", IMemAddr, 32'h0);
        wait_valid("post_rst");
        chk("post_rst_prog", ProgAddr, 32'h0);

        // Misaligned absolute redirect
        BranchTaken    = 1'b1;
        AbsoluteBranch = 1'b1;
        BranchAddr     = 32'h102;
`ifdef FETCH_ALIGN_CHECK_EN
        step();
        BranchTaken = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mis_fault", 32'(FetchFault), 32'd1);
            chk("mis_req",   32'(IMemReq),    32'd0);
            chk("mis_valid", 32'(InsValid),   32'd0);
            step();
        end
        nReset = 1'b0;
        #1;
        chk("mis_rst_fault", 32'(FetchFault), 32'd0);
        exp_req.push_back(32'h0);
        step();
        nReset = 1'b1;
        wait_valid("mis_rst");
`else
        exp_req.push_back(32'h100);
        step();
        BranchTaken = 1'b0;
        chk("mis_fault", 32'(FetchFault), 32'd0);
        chk("mis_req",   32'(IMemReq),    32'd1);
        chk("mis_addr",  IMemAddr,        32'h100);
        wait_valid("mis");
        chk("mis_prog",  ProgAddr,        32'h100);
`endif

        // Wrapping reset vector and drained scoreboards
        repeat (4) step();
        chk("wrap_count", 32'(n2),      32'd2);
        chk("wrap_first", cap2[0],      32'hFFFF_FFFC);
        chk("wrap_next",  cap2[1],      32'h0);
        chk("wrap_fault", 32'(fault2),  32'd0);
        chk("req_left",   32'(exp_req.size()), 32'd0);
        chk("ins_left",   32'(exp_ins.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
